// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side SRAM-like bus.
//   SIZE_*         : encodings of the 2-bit transfer size field
//   owner_t        : which requester owns an outstanding transaction
//   grant_state_t  : states of the address-phase grant FSM in sram_req_arbiter
package cpu_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } grant_state_t;

endpackage

// File: rtl/owner_fifo.sv
// Small FIFO that remembers, in acceptance order, which requester owns each
// outstanding transaction on the shared port.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push, din  : append an owner (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   dout       : owner at the head of the FIFO
//   full/empty : derived from the registered occupancy count
module owner_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  owner_t din,
  output owner_t dout,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  owner_t             mem_q [DEPTH];
  owner_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok;
  logic               pop_ok;

  // Pointers wrap explicitly so DEPTH need not match the pointer range.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= OWN_INST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates one SRAM-like split-transaction port between instruction fetch
// (inst_*) and data access (data_*). Data has fixed priority when idle; once a
// request is shown without acceptance the grant is locked to that side until
// addr_ok. Every accepted transaction records its owner so in-order responses
// (data_ok/rdata) are routed back to the right requester.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   inst_* / data_* (req..wdata)       : requester address phase inputs
//   inst_/data_addr_ok                 : address phase accepted for that side
//   inst_/data_data_ok, *_rdata        : response routed to that side
//   req, wr, size, addr, wstrb, wdata  : shared port request
//   addr_ok, data_ok, rdata            : shared port handshake / response
module sram_req_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTS   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata
);

  grant_state_t state_q, state_d;
  logic         grant_valid;
  owner_t       grant_owner;
  logic         side_req;
  logic         accept;
  logic         fifo_full;
  logic         fifo_empty;
  owner_t       head_owner;
  logic         resp_valid;

  // Grant selection and next state. Full is taken from the registered FIFO
  // count, so a pop in the same cycle does not reopen the port.
  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_owner = OWN_INST;
    case (state_q)
      ST_IDLE: begin
        if (data_req) begin
          grant_valid = 1'b1;
          grant_owner = OWN_DATA;
        end else if (inst_req) begin
          grant_valid = 1'b1;
          grant_owner = OWN_INST;
        end
      end
      ST_LOCK_I: begin
        grant_valid = 1'b1;
        grant_owner = OWN_INST;
      end
      ST_LOCK_D: begin
        grant_valid = 1'b1;
        grant_owner = OWN_DATA;
      end
      default: begin
        grant_valid = 1'b0;
      end
    endcase

    side_req = (grant_owner == OWN_DATA) ? data_req : inst_req;
    req      = grant_valid & side_req & ~fifo_full;
    accept   = req & addr_ok;

    if (state_q == ST_IDLE) begin
      if (req && !addr_ok) begin
        state_d = (grant_owner == OWN_DATA) ? ST_LOCK_D : ST_LOCK_I;
      end
    end else if (accept) begin
      state_d = ST_IDLE;
    end
  end

  // Request fields follow the granted side, zero when nobody holds the grant.
  always_comb begin
    wr    = 1'b0;
    size  = '0;
    addr  = '0;
    wstrb = '0;
    wdata = '0;
    if (grant_valid) begin
      if (grant_owner == OWN_DATA) begin
        wr    = data_wr;
        size  = data_size;
        addr  = data_addr;
        wstrb = data_wstrb;
        wdata = data_wdata;
      end else begin
        wr    = inst_wr;
        size  = inst_size;
        addr  = inst_addr;
        wstrb = inst_wstrb;
        wdata = inst_wdata;
      end
    end
  end

  // Responses with nothing outstanding are protocol errors and are dropped;
  // rdata is only forwarded to the side that owns the head entry.
  assign resp_valid   = data_ok & ~fifo_empty;
  assign inst_addr_ok = accept & (grant_owner == OWN_INST);
  assign data_addr_ok = accept & (grant_owner == OWN_DATA);
  assign inst_data_ok = resp_valid & (head_owner == OWN_INST);
  assign data_data_ok = resp_valid & (head_owner == OWN_DATA);
  assign inst_rdata   = (!fifo_empty && head_owner == OWN_INST) ? rdata : '0;
  assign data_rdata   = (!fifo_empty && head_owner == OWN_DATA) ? rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  owner_fifo #(
    .DEPTH(OUTS)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (data_ok),
    .din   (grant_owner),
    .dout  (head_owner),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter. A stimulus process drives one
// cycle at a time and pushes the expected outputs (from a queue-based model
// of ownership and grant locking) into a scoreboard; a monitor pops one entry
// per cycle on the falling edge and compares it with the DUT.
module tb_sram_req_arbiter;

  localparam int OUTS = 2;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  typedef struct {
    bit          chk;
    int          cyc;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        iaok;
    logic        daok;
    logic        idok;
    logic        ddok;
    logic [31:0] irdata;
    logic [31:0] drdata;
  } exp_t;

  exp_t sb[$];
  bit   own_q[$];
  int   lock_side;
  int   cyc;
  int   checks;
  int   errors;
  bit   inst_pend, data_pend;

  sram_req_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTS(OUTS)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, c, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          compare("req",          e.cyc, 32'(req),          32'(e.req));
          compare("wr",           e.cyc, 32'(wr),           32'(e.wr));
          compare("size",         e.cyc, 32'(size),         32'(e.size));
          compare("addr",         e.cyc, addr,              e.addr);
          compare("wstrb",        e.cyc, 32'(wstrb),        32'(e.wstrb));
          compare("wdata",        e.cyc, wdata,             e.wdata);
          compare("inst_addr_ok", e.cyc, 32'(inst_addr_ok), 32'(e.iaok));
          compare("data_addr_ok", e.cyc, 32'(data_addr_ok), 32'(e.daok));
          compare("inst_data_ok", e.cyc, 32'(inst_data_ok), 32'(e.idok));
          compare("data_data_ok", e.cyc, 32'(data_data_ok), 32'(e.ddok));
          compare("inst_rdata",   e.cyc, inst_rdata,        e.irdata);
          compare("data_rdata",   e.cyc, data_rdata,        e.drdata);
        end
      end
    end
  end

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    addr_ok = 0; data_ok = 0; rdata = 0;
  endtask

  // Predict this cycle's outputs from the model, queue them, advance the
  // model, then move to just after the next rising edge.
  task automatic applyStimulus(output bit inst_acc, output bit data_acc);
    exp_t e;
    int   side;
    bit   full;
    bit   pop;
    e = '{default: 0};
    e.chk = !reset;
    e.cyc = cyc;
    full = (own_q.size() == OUTS);
    side = lock_side;
    if (side < 0) side = data_req ? 1 : (inst_req ? 0 : -1);
    if (side == 1) begin
      e.req = data_req & ~full;
      e.wr = data_wr; e.size = data_size; e.addr = data_addr;
      e.wstrb = data_wstrb; e.wdata = data_wdata;
    end else if (side == 0) begin
      e.req = inst_req & ~full;
      e.wr = inst_wr; e.size = inst_size; e.addr = inst_addr;
      e.wstrb = inst_wstrb; e.wdata = inst_wdata;
    end
    e.iaok = e.req & addr_ok & (side == 0);
    e.daok = e.req & addr_ok & (side == 1);
    pop = data_ok && (own_q.size() > 0);
    if (own_q.size() > 0) begin
      if (own_q[0]) begin
        e.drdata = rdata;
        e.ddok   = data_ok;
      end else begin
        e.irdata = rdata;
        e.idok   = data_ok;
      end
    end
    sb.push_back(e);
    inst_acc = !reset && e.iaok;
    data_acc = !reset && e.daok;
    if (reset) begin
      own_q.delete();
      lock_side = -1;
    end else begin
      if (pop) void'(own_q.pop_front());
      if (e.req && addr_ok) begin
        own_q.push_back(side == 1);
        lock_side = -1;
      end else if (e.req) begin
        lock_side = side;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic stepN(input int n);
    bit ia, da;
    for (int i = 0; i < n; i++) applyStimulus(ia, da);
  endtask

  task automatic doReset();
    clear_inputs();
    reset = 1;
    stepN(2);
    reset = 0;
  endtask

  // Wait for the monitor to drain the scoreboard, bounded by a cycle budget.
  task automatic checkOutput();
    int budget;
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    bit ia, da;
    checks = 0; errors = 0; cyc = 0; lock_side = -1;
    inst_pend = 0; data_pend = 0;
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    doReset();

    // Reset state: nothing requested, everything quiet.
    stepN(1);

    // Single fetch, accepted at once, answered next cycle.
    inst_req = 1; inst_size = 2; inst_addr = 32'h1c000000; addr_ok = 1;
    stepN(1);
    clear_inputs(); data_ok = 1; rdata = 32'h02800c0c;
    stepN(1);
    clear_inputs(); stepN(1);

    // Simultaneous requests: data first, then inst; responses D then I.
    inst_req = 1; inst_size = 2; inst_addr = 32'h1c000004;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h00000100;
    data_wstrb = 4'hf; data_wdata = 32'hdeadbeef; addr_ok = 1;
    stepN(1);
    data_req = 0; data_wr = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    stepN(1);
    clear_inputs(); data_ok = 1; rdata = 32'h11111111;
    stepN(1);
    rdata = 32'h22222222;
    stepN(1);
    clear_inputs(); stepN(1);

    // Lock: inst shown without accept while data rises.
    inst_req = 1; inst_size = 2; inst_addr = 32'h1c000008;
    stepN(1);
    data_req = 1; data_size = 1; data_addr = 32'h00000200;
    stepN(2);
    addr_ok = 1;
    stepN(1);
    inst_req = 0; inst_addr = 0;
    stepN(1);
    clear_inputs(); data_ok = 1; rdata = 32'h33333333;
    stepN(2);
    clear_inputs(); stepN(1);

    // Full FIFO holds off req, a same-cycle pop does not reopen it.
    inst_req = 1; inst_size = 2; inst_addr = 32'h1c000010; addr_ok = 1;
    stepN(2);
    stepN(1);
    data_ok = 1; rdata = 32'h44444444;
    stepN(1);
    data_ok = 0;
    stepN(1);
    inst_req = 0; inst_addr = 0; addr_ok = 0; data_ok = 1; rdata = 32'h55555555;
    stepN(2);

    // Response with nothing outstanding is ignored.
    clear_inputs(); data_ok = 1; rdata = 32'h66666666;
    stepN(2);
    clear_inputs(); stepN(1);

    // Reset in the middle of LOCK_D with a transaction in flight.
    data_req = 1; data_size = 2; data_addr = 32'h00000300; addr_ok = 1;
    stepN(1);
    addr_ok = 0; data_addr = 32'h00000304;
    stepN(1);
    reset = 1;
    stepN(1);
    reset = 0; clear_inputs();
    stepN(1);
    data_ok = 1; rdata = 32'h77777777;
    stepN(1);
    clear_inputs(); inst_req = 1; inst_addr = 32'h1c000020; addr_ok = 1;
    stepN(1);
    clear_inputs(); data_ok = 1; rdata = 32'h88888888;
    stepN(1);
    clear_inputs();

    // Randomised traffic; requesters hold their request until accepted.
    for (int n = 0; n < 3000; n++) begin
      if (!inst_pend && $urandom_range(99) < 35) begin
        inst_pend = 1; inst_wr = 1'($urandom_range(1)); inst_size = 2'($urandom_range(2));
        inst_addr = $urandom; inst_wstrb = 4'($urandom); inst_wdata = $urandom;
      end
      if (!data_pend && $urandom_range(99) < 35) begin
        data_pend = 1; data_wr = 1'($urandom_range(1)); data_size = 2'($urandom_range(2));
        data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
      end
      inst_req = inst_pend;
      data_req = data_pend;
      addr_ok  = ($urandom_range(99) < 50);
      data_ok  = (own_q.size() > 0) ? ($urandom_range(99) < 35) : ($urandom_range(99) < 5);
      rdata    = $urandom;
      reset    = ($urandom_range(299) == 0);
      applyStimulus(ia, da);
      if (ia) inst_pend = 0;
      if (da) data_pend = 0;
    end
    reset = 0;
    clear_inputs();
    stepN(1);

    checkOutput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
